// File: rtl/wdt_timeout_ctrl_if.sv
// ============================================================================
//  Module   : wdt_timeout_ctrl_if
//  Brief    : WTO input, firmware handshake and status bundle for the
//             watchdog timeout controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface wdt_timeout_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             wto_i;
    logic             irq_ack_i;
    logic             irq_mask_i;
    logic             irq_o;
    logic             sys_rst_req_o;
    logic [CNT_W-1:0] wto_cnt_o;
    logic [1:0]       state_o;

    // slave: the timeout controller; master: the watchdog/CPU side driving it
    modport slave (
        input  wto_i,
        input  irq_ack_i,
        input  irq_mask_i,
        output irq_o,
        output sys_rst_req_o,
        output wto_cnt_o,
        output state_o
    );

    modport master (
        output wto_i,
        output irq_ack_i,
        output irq_mask_i,
        input  irq_o,
        input  sys_rst_req_o,
        input  wto_cnt_o,
        input  state_o
    );
endinterface

`default_nettype wire

// File: rtl/wdt_timeout_ctrl.sv
// ============================================================================
//  Module   : wdt_timeout_ctrl
//  Brief    : Synchronises WTO, raises a maskable IRQ, escalates to a fixed
//             system-reset pulse if firmware does not acknowledge in time.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module wdt_timeout_ctrl #(
    parameter int GRACE_CYCLES = 1024,
    parameter int RST_PULSE    = 16,
    parameter int CNT_W        = 8    // must match the interface CNT_W
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    wdt_timeout_ctrl_if.slave   bus
);

    localparam int GW = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;
    localparam int PW = (RST_PULSE > 1)    ? $clog2(RST_PULSE)    : 1;

    localparam logic [GW-1:0]    GRACE_LAST = GW'(GRACE_CYCLES - 1);
    localparam logic [PW-1:0]    PULSE_LAST = PW'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IRQ  = 2'd1,
        ST_RST  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t           state_q;
    logic             s1_q;
    logic             s2_q;
    logic             s3_q;
    logic [GW-1:0]    gcnt_q;
    logic [PW-1:0]    pcnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rise_w;

    assign rise_w = s2_q & ~s3_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            gcnt_q  <= '0;
            pcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            s1_q <= bus.wto_i;
            s2_q <= s1_q;
            s3_q <= s2_q;

            if (rise_w && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rise_w) begin
                        state_q <= ST_IRQ;
                        gcnt_q  <= '0;
                    end
                end
                ST_IRQ: begin
                    // An acknowledge in the expiry cycle still cancels escalation
                    if (bus.irq_ack_i) begin
                        state_q <= ST_IDLE;
                    end else if (gcnt_q == GRACE_LAST) begin
                        state_q <= ST_RST;
                        pcnt_q  <= '0;
                    end else begin
                        gcnt_q <= gcnt_q + 1'b1;
                    end
                end
                ST_RST: begin
                    if (pcnt_q == PULSE_LAST) begin
                        state_q <= ST_HOLD;
                    end else begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Wait for WTO to clear so a persistent timeout cannot re-arm
                    if (!s2_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.irq_o         = (state_q == ST_IRQ) & ~bus.irq_mask_i;
    assign bus.sys_rst_req_o = (state_q == ST_RST);
    assign bus.wto_cnt_o     = cnt_q;
    assign bus.state_o       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_wdt_timeout_ctrl.sv
// ============================================================================
//  Module   : tb_wdt_timeout_ctrl
//  Brief    : Self-checking bench for wdt_timeout_ctrl (two counter widths).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wdt_timeout_ctrl;

    localparam int GRACE = 8;
    localparam int PULSE = 16;

    logic ACLK = 1'b0;
    logic rstn = 1'b0;
    logic wto  = 1'b0;
    logic ack  = 1'b0;
    logic mask = 1'b0;

    always #5 ACLK = ~ACLK;

    wdt_timeout_ctrl_if #(.CNT_W(8)) ifa ();
    wdt_timeout_ctrl_if #(.CNT_W(2)) ifb ();

    assign ifa.wto_i      = wto;
    assign ifa.irq_ack_i  = ack;
    assign ifa.irq_mask_i = mask;
    assign ifb.wto_i      = wto;
    assign ifb.irq_ack_i  = ack;
    assign ifb.irq_mask_i = mask;

    wdt_timeout_ctrl #(.GRACE_CYCLES(GRACE), .RST_PULSE(PULSE), .CNT_W(8)) u_dut_a (
        .ACLK    (ACLK),
        .ARESETn (rstn),
        .bus     (ifa)
    );

    wdt_timeout_ctrl #(.GRACE_CYCLES(GRACE), .RST_PULSE(PULSE), .CNT_W(2)) u_dut_b (
        .ACLK    (ACLK),
        .ARESETn (rstn),
        .bus     (ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: timestamps and unbounded event count, saturated on read
    int     m_st   = 0;
    int     m_cnt  = 0;
    longint m_edge = 0;
    longint m_until = 0;
    bit     hq[3]  = '{1'b0, 1'b0, 1'b0};

    task automatic model_step();
        bit rise;
        if (!rstn) begin
            m_st  = 0;
            m_cnt = 0;
            hq    = '{1'b0, 1'b0, 1'b0};
        end else begin
            m_edge++;
            rise = hq[1] && !hq[2];
            case (m_st)
                0: if (rise) begin m_st = 1; m_until = m_edge + GRACE; end
                1: if (ack) m_st = 0;
                   else if (m_edge == m_until) begin m_st = 2; m_until = m_edge + PULSE; end
                2: if (m_edge == m_until) m_st = 3;
                default: if (!hq[1]) m_st = 0;
            endcase
            if (rise) m_cnt++;
            hq[2] = hq[1];
            hq[1] = hq[0];
            hq[0] = wto;
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        model_step();
        #1;
        chk("model_state_a", int'(ifa.state_o), m_st);
        chk("model_state_b", int'(ifb.state_o), m_st);
        chk("model_irq",     int'(ifa.irq_o), int'(m_st == 1 && !mask));
        chk("model_rst",     int'(ifa.sys_rst_req_o), int'(m_st == 2));
        chk("model_cnt_a",   int'(ifa.wto_cnt_o), (m_cnt > 255) ? 255 : m_cnt);
        chk("model_cnt_b",   int'(ifb.wto_cnt_o), (m_cnt > 3) ? 3 : m_cnt);
    endtask

    task automatic do_reset();
        rstn = 1'b0; wto = 1'b0; ack = 1'b0; mask = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    typedef struct {
        logic       rstn;
        logic       wto;
        logic       ack;
        logic       mask;
        logic       irq;
        logic       rst;
        logic [1:0] st;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int irq_n;
        int rst_n;
        int waited;
        logic [1:0] exp_b[5];

        // rstn wto ack mask | irq rst st cnt   (expected after the edge)
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 2'd0, 8'd0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 2'd0, 8'd0};
        vecs[2]  = '{1, 1, 0, 0, 0, 0, 2'd0, 8'd0};
        vecs[3]  = '{1, 1, 0, 0, 0, 0, 2'd0, 8'd0};
        vecs[4]  = '{1, 1, 0, 0, 1, 0, 2'd1, 8'd1};
        vecs[5]  = '{1, 1, 0, 0, 1, 0, 2'd1, 8'd1};
        vecs[6]  = '{1, 1, 0, 0, 1, 0, 2'd1, 8'd1};
        vecs[7]  = '{1, 1, 0, 0, 1, 0, 2'd1, 8'd1};
        vecs[8]  = '{1, 1, 0, 0, 1, 0, 2'd1, 8'd1};
        vecs[9]  = '{1, 1, 1, 0, 0, 0, 2'd0, 8'd1};
        vecs[10] = '{1, 0, 0, 0, 0, 0, 2'd0, 8'd1};
        vecs[11] = '{1, 0, 0, 0, 0, 0, 2'd0, 8'd1};
        vecs[12] = '{1, 1, 0, 1, 0, 0, 2'd0, 8'd1};
        vecs[13] = '{1, 1, 0, 1, 0, 0, 2'd0, 8'd1};
        vecs[14] = '{1, 1, 0, 1, 0, 0, 2'd1, 8'd2};
        vecs[15] = '{1, 1, 0, 0, 1, 0, 2'd1, 8'd2};
        vecs[16] = '{1, 1, 1, 0, 0, 0, 2'd0, 8'd2};

        for (int i = 0; i < 17; i++) begin
            rstn = vecs[i].rstn; wto = vecs[i].wto; ack = vecs[i].ack; mask = vecs[i].mask;
            tick();
            chk($sformatf("vec%0d_irq", i), int'(ifa.irq_o), int'(vecs[i].irq));
            chk($sformatf("vec%0d_rst", i), int'(ifa.sys_rst_req_o), int'(vecs[i].rst));
            chk($sformatf("vec%0d_state", i), int'(ifa.state_o), int'(vecs[i].st));
            chk($sformatf("vec%0d_cnt", i), int'(ifa.wto_cnt_o), int'(vecs[i].cnt));
        end

        // No acknowledge: full grace window, reset pulse, then hold until WTO clears
        do_reset();
        wto = 1'b1;
        irq_n = 0; rst_n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ifa.irq_o) irq_n++;
            if (ifa.sys_rst_req_o) rst_n++;
        end
        chk("noack_irq_cycles", irq_n, GRACE);
        chk("noack_rst_cycles", rst_n, PULSE);
        chk("noack_hold", int'(ifa.state_o), 3);
        wto = 1'b0;
        tick();
        chk("hold_fall_e1", int'(ifa.state_o), 3);
        tick();
        chk("hold_fall_e2", int'(ifa.state_o), 3);
        tick();
        chk("hold_fall_e3", int'(ifa.state_o), 0);

        // Acknowledge in the expiry cycle wins
        do_reset();
        wto = 1'b1;
        repeat (3) tick();
        chk("exp_enter_irq", int'(ifa.state_o), 1);
        repeat (GRACE - 1) tick();
        chk("exp_last_irq", int'(ifa.state_o), 1);
        ack = 1'b1;
        tick();
        chk("exp_ack_state", int'(ifa.state_o), 0);
        chk("exp_ack_rst", int'(ifa.sys_rst_req_o), 0);
        ack = 1'b0;
        rst_n = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (ifa.sys_rst_req_o) rst_n++;
        end
        chk("exp_no_rst", rst_n, 0);

        // Masked interrupt: no irq_o but escalation still runs
        do_reset();
        mask = 1'b1; wto = 1'b1;
        irq_n = 0; rst_n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ifa.irq_o) irq_n++;
            if (ifa.sys_rst_req_o) rst_n++;
        end
        chk("mask_irq_cycles", irq_n, 0);
        chk("mask_rst_cycles", rst_n, PULSE);
        mask = 1'b0; wto = 1'b0;
        repeat (4) tick();

        // Counter saturation on the narrow instance
        do_reset();
        exp_b[0] = 2'd1; exp_b[1] = 2'd2; exp_b[2] = 2'd3; exp_b[3] = 2'd3; exp_b[4] = 2'd3;
        for (int p = 0; p < 5; p++) begin
            wto = 1'b1;
            repeat (3) tick();
            chk($sformatf("sat_b_p%0d", p), int'(ifb.wto_cnt_o), int'(exp_b[p]));
            chk($sformatf("sat_a_p%0d", p), int'(ifa.wto_cnt_o), p + 1);
            ack = 1'b1; wto = 1'b0;
            tick();
            ack = 1'b0;
            repeat (3) tick();
        end

        // Reset in the middle of the reset pulse
        wto = 1'b1;
        waited = 0;
        while (!ifa.sys_rst_req_o && waited < 30) begin
            tick();
            waited++;
        end
        chk("midrst_reached", int'(ifa.sys_rst_req_o), 1);
        repeat (3) tick();
        rstn = 1'b0;
        tick();
        chk("midrst_rst", int'(ifa.sys_rst_req_o), 0);
        chk("midrst_irq", int'(ifa.irq_o), 0);
        chk("midrst_cnt", int'(ifa.wto_cnt_o), 0);
        chk("midrst_state", int'(ifa.state_o), 0);
        wto = 1'b0;
        rstn = 1'b1;
        tick();

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) wto = ~wto;
            ack  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 49) == 0) mask = ~mask;
            rstn = ($urandom_range(0, 799) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
